alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Initiator side of the combinational ALU interface. Accepts operation requests over a valid/ready handshake and drives the ALU's a/b/alu_control inputs. Samples result/zero and returns a registered response over a second valid/ready handshake.
- Adds compound operations built from multiple ALU passes: absolute difference, max, and low-word multiply.
- Sits between the datapath control and the shared ALU instance, for multi-cycle extended instructions.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU (32).
- MUL_EN, 1, 1 = op 111 is multiply; 0 = op 111 is a single-pass add.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_op  input  3  operation code (see Behaviour)
- req_a  input  DATA_W  operand A
- req_b  input  DATA_W  operand B
- alu_a  output  DATA_W  to ALU input a
- alu_b  output  DATA_W  to ALU input b
- alu_control  output  3  to ALU alu_control (000 add, 001 sub, 010 and, 011 or, 100 slt)
- alu_result  input  DATA_W  from ALU result, combinational same cycle
- alu_zero  input  1  from ALU zero, unused for final zero flag
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  DATA_W  final result
- rsp_zero  output  1  1 when rsp_result == 0
- busy  output  1  state != IDLE

Behaviour:
- Single clock domain; reset is synchronous and active-high. Reset is sampled on the clk rising edge.
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_result=0, rsp_zero=1, busy=0.
  - req_ready=1 after the reset cycle.
  - alu_a=0, alu_b=0, alu_control=000.
- Reset mid-operation aborts the operation. No response is ever produced for the aborted request.
- Handshakes:
  - Request accepted on a cycle with req_valid && req_ready. req_ready = (state==IDLE). req_a, req_b and req_op are captured into internal registers opa, opb and op.
  - Response transferred on a cycle with rsp_valid && rsp_ready. rsp_valid, rsp_result and rsp_zero hold stable until then.
  - No overlap: req_ready stays 0 until the response is taken. The sequencer returns to IDLE the cycle after transfer.
- ALU drive:
  - alu_a, alu_b and alu_control are decoded combinationally from state and internal registers.
  - In IDLE and DONE the ALU outputs are 0/0/000.
  - alu_result is sampled at the rising edge ending each execute cycle.
- Op codes:
  - 000–100: single pass with alu_control = req_op.
  - 101: ABSDIFF.
  - 110: MAX (signedness per ALU slt).
  - 111: MUL (low DATA_W bits), or add if MUL_EN=0.
- States: IDLE, PASS1, PASS2, MUL, DONE.
  - IDLE -> accept: MUL if op==111 and MUL_EN; otherwise PASS1.
  - PASS1: drive (opa, opb, ctl).
    - For single-pass ops: ctl = op; result <= alu_result; go to DONE.
    - For 101/110: ctl = 100 (slt); lt <= alu_result[0]; go to PASS2.
  - PASS2, op 101: lt ? (opb, opa, sub) : (opa, opb, sub).
  - PASS2, op 110: lt ? (opb, 0, add) : (opa, 0, add).
  - PASS2: result <= alu_result; go to DONE.
  - MUL: init acc=0, mcand=opa, mult=opb at accept. Each cycle:
    - Drive (acc, mcand, add).
    - If mult[0], acc <= alu_result.
    - mcand <= mcand<<1; mult <= mult>>1.
    - If (mult>>1)==0, result <= updated acc and go to DONE.
  - DONE: rsp_valid=1, rsp_zero = (result==0). On rsp_ready go to IDLE.
- Latency (accept edge = T):
  - Single-pass: rsp_valid at T+2.
  - ABSDIFF/MAX: rsp_valid at T+3.
  - MUL: rsp_valid at T+1+max(1, msb_index(opb)+1). opb=0 and opb=1 both take 1 MUL cycle.
- Arithmetic wraps modulo 2^DATA_W; there is no overflow flag. rsp_zero is computed from rsp_result, never from alu_zero.
- req_valid while busy is ignored; the requester must hold it, since req_ready=0.

Test Plan:
- Reset, then req op=001, a=7, b=7, rsp_ready=1 -> rsp_valid at T+2; rsp_result=0, rsp_zero=1. ALU saw alu_control=001 at T+1.
- ABSDIFF a=3, b=10 -> PASS1 ctl=100, PASS2 drives (10, 3, 001); rsp_result=7 at T+3. Repeat with a=10, b=3 -> 7.
- MAX a=0x20, b=0x15 -> rsp_result=0x20, rsp_zero=0. MAX a=0, b=0 -> 0, rsp_zero=1.
- MUL a=6, b=5 -> 3 MUL cycles, rsp_result=30 at T+4. MUL a=0xFFFFFFFF, b=2 -> 0xFFFFFFFE (wrap). MUL b=0 -> result 0 at T+2.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> response held stable, req_ready=0. A second req_valid is not accepted until the cycle after rsp_ready=1.
- Assert reset during a MUL with b=0x80000000 -> next cycle state IDLE, rsp_valid=0, busy=0. No stale response appears afterward.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Bundles the request handshake, the response handshake and the ALU drive/return
// signals of the ALU operation sequencer.
//   req_*   : request channel (valid/ready, 3-bit op, operands a/b)
//   rsp_*   : response channel (valid/ready, result, zero flag)
//   alu_*   : operands/control to the shared combinational ALU and its result back
//   busy    : sequencer is not idle
// Modports:
//   slave  : the sequencer itself
//   master : the requester / ALU / response consumer side
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_control;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;

  logic              busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_result, rsp_zero, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_result, rsp_zero, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Initiator for a shared combinational ALU. Accepts one operation request at a
// time, drives the ALU for one or more passes and returns a registered response.
// Op codes 000-100 are single ALU passes; 101 = absolute difference, 110 = signed
// max (two passes: slt then sub/add); 111 = low-word shift-and-add multiply (or a
// plain add when MUL_EN = 0).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (aborts any operation in flight)
//   bus   : alu_op_sequencer_if.slave (request, response and ALU signals, busy)
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  alu_op_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, PASS1, PASS2, MUL, DONE} state_t;

  localparam logic [2:0] CTL_ADD = 3'b000;
  localparam logic [2:0] CTL_SUB = 3'b001;
  localparam logic [2:0] CTL_SLT = 3'b100;
  localparam logic [2:0] OP_ABSDIFF = 3'b101;
  localparam logic [2:0] OP_MAX = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t            state, state_next;
  logic [DATA_W-1:0] opa, opb, result;
  logic [DATA_W-1:0] acc, mcand, mult;
  logic [DATA_W-1:0] acc_upd;
  logic [2:0]        op;
  logic              lt;
  logic              accept;
  logic              two_pass;
  logic              mul_last;
  logic              unused_alu_zero;

  // The ALU zero flag is not trusted for the final flag (compound ops change it).
  assign unused_alu_zero = bus.alu_zero;

  assign accept   = bus.req_valid && (state == IDLE);
  assign two_pass = (op == OP_ABSDIFF) || (op == OP_MAX);
  // Accumulate only when the current multiplier bit is set.
  assign acc_upd  = mult[0] ? bus.alu_result : acc;
  // Last multiply step once no set bits remain above the current one.
  assign mul_last = ((mult >> 1) == '0);

  assign bus.req_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.rsp_valid  = (state == DONE);
  assign bus.rsp_result = result;
  assign bus.rsp_zero   = (result == '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ((bus.req_op == OP_MUL) && MUL_EN) ? MUL : PASS1;
        end
      end
      PASS1: state_next = two_pass ? PASS2 : DONE;
      PASS2: state_next = DONE;
      MUL: begin
        if (mul_last) state_next = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // PASS2 reuses the slt outcome: absdiff swaps operands of a sub so the
  // result is non-negative, max routes the larger operand through an add of 0.
  always_comb begin
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_control = CTL_ADD;
    case (state)
      PASS1: begin
        bus.alu_a = opa;
        bus.alu_b = opb;
        if (two_pass)         bus.alu_control = CTL_SLT;
        else if (op == OP_MUL) bus.alu_control = CTL_ADD;
        else                  bus.alu_control = op;
      end
      PASS2: begin
        if (op == OP_ABSDIFF) begin
          bus.alu_a       = lt ? opb : opa;
          bus.alu_b       = lt ? opa : opb;
          bus.alu_control = CTL_SUB;
        end else begin
          bus.alu_a       = lt ? opb : opa;
          bus.alu_b       = '0;
          bus.alu_control = CTL_ADD;
        end
      end
      MUL: begin
        bus.alu_a       = acc;
        bus.alu_b       = mcand;
        bus.alu_control = CTL_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      op     <= '0;
      lt     <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mult   <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            opa   <= bus.req_a;
            opb   <= bus.req_b;
            op    <= bus.req_op;
            acc   <= '0;
            mcand <= bus.req_a;
            mult  <= bus.req_b;
          end
        end
        PASS1: begin
          if (two_pass) lt <= bus.alu_result[0];
          else          result <= bus.alu_result;
        end
        PASS2: result <= bus.alu_result;
        MUL: begin
          acc   <= acc_upd;
          mcand <= mcand << 1;
          mult  <= mult >> 1;
          if (mul_last) result <= acc_upd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer: models the shared ALU, drives a table
// of directed vectors, hand-written backpressure/reset-abort sequences and
// randomized requests checked against a behavioural reference model.
module tb_alu_op_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  alu_op_sequencer_if #(.DATA_W(32)) bus ();

  alu_op_sequencer #(.DATA_W(32), .MUL_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU that the sequencer drives.
  always_comb begin
    case (bus.alu_control)
      3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      default: bus.alu_result = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    int          cycles;
  } vec_t;

  vec_t vecs[10];

  // Behavioural reference: what each op means arithmetically.
  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: r = ($signed(a) < $signed(b)) ? (b - a) : (a - b);
      3'd6: r = ($signed(a) < $signed(b)) ? b : a;
      default: r = a * b;
    endcase
    return r;
  endfunction

  // Execute cycles between accept and response: 1, 2, or the bit length of b.
  function automatic int refCycles(input logic [2:0] op, input logic [31:0] b);
    logic [32:0] bp1;
    int          n;
    if (op <= 3'd4) return 1;
    if (op != 3'd7) return 2;
    bp1 = {1'b0, b} + 33'd1;
    n = $clog2(bp1);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic logic [2:0] refFirstCtl(input logic [2:0] op);
    if (op <= 3'd4) return op;
    if (op == 3'd7) return 3'd0;
    return 3'd4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitRsp(input int budget, output int n);
    n = 0;
    while (!bus.rsp_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.rsp_valid) checkOutput("rsp_timeout", 32'd0, 32'd1);
  endtask

  // One full transaction; caller is at #1 after a rising edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_result, input logic exp_zero,
                               input int exp_cycles, input int rsp_delay);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    checkOutput("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkOutput("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    checkOutput("first_alu_control", {29'd0, bus.alu_control}, {29'd0, refFirstCtl(op)});
    waitRsp(100, n);
    checkOutput("latency", n, exp_cycles);
    repeat (rsp_delay) begin
      @(posedge clk); #1;
    end
    checkOutput("rsp_result", bus.rsp_result, exp_result);
    checkOutput("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, exp_zero});
    checkOutput("alu_idle_in_done", {29'd0, bus.alu_control}, 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checkOutput("rsp_valid_cleared", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int stale;
    logic [31:0] held;
    checks = 0;
    fails  = 0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    reset         = 1'b1;

    vecs[0] = '{3'd1, 32'd7, 32'd7, 32'd0, 1'b1, 1};
    vecs[1] = '{3'd5, 32'd3, 32'd10, 32'd7, 1'b0, 2};
    vecs[2] = '{3'd5, 32'd10, 32'd3, 32'd7, 1'b0, 2};
    vecs[3] = '{3'd6, 32'h20, 32'h15, 32'h20, 1'b0, 2};
    vecs[4] = '{3'd6, 32'd0, 32'd0, 32'd0, 1'b1, 2};
    vecs[5] = '{3'd7, 32'd6, 32'd5, 32'd30, 1'b0, 3};
    vecs[6] = '{3'd7, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 2};
    vecs[7] = '{3'd7, 32'h1234, 32'd0, 32'd0, 1'b1, 1};
    vecs[8] = '{3'd4, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1};
    vecs[9] = '{3'd6, 32'hFFFFFFF0, 32'd5, 32'd5, 1'b0, 2};

    @(posedge clk); #1;
    checkOutput("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("reset_rsp_result", bus.rsp_result, 32'd0);
    checkOutput("reset_rsp_zero", {31'd0, bus.rsp_zero}, 32'd1);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_alu_a", bus.alu_a, 32'd0);
    checkOutput("reset_alu_b", bus.alu_b, 32'd0);
    checkOutput("reset_alu_control", {29'd0, bus.alu_control}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].result, vecs[i].zero,
                    vecs[i].cycles, i % 3);
    end

    // ABSDIFF pass-by-pass ALU drive.
    bus.req_valid = 1'b1; bus.req_op = 3'd5; bus.req_a = 32'd3; bus.req_b = 32'd10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkOutput("absdiff_p1_ctl", {29'd0, bus.alu_control}, 32'd4);
    @(posedge clk); #1;
    checkOutput("absdiff_p2_a", bus.alu_a, 32'd10);
    checkOutput("absdiff_p2_b", bus.alu_b, 32'd3);
    checkOutput("absdiff_p2_ctl", {29'd0, bus.alu_control}, 32'd1);
    waitRsp(10, n);
    checkOutput("absdiff_result", bus.rsp_result, 32'd7);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    $display("[TB] backpressure");
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 32'd1; bus.req_b = 32'd2;
    @(posedge clk); #1;
    bus.req_a = 32'd5; bus.req_b = 32'd6;
    waitRsp(10, n);
    held = bus.rsp_result;
    checkOutput("bp_first_result", held, 32'd3);
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("bp_valid_held", {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput("bp_result_held", bus.rsp_result, 32'd3);
      checkOutput("bp_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checkOutput("bp_idle_after_take", {31'd0, bus.busy}, 32'd0);
    checkOutput("bp_rsp_valid_low", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkOutput("bp_second_accepted", {31'd0, bus.busy}, 32'd1);
    waitRsp(10, n);
    checkOutput("bp_second_result", bus.rsp_result, 32'd11);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    $display("[TB] reset during multiply");
    bus.req_valid = 1'b1; bus.req_op = 3'd7; bus.req_a = 32'd3; bus.req_b = 32'h80000000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("mul_in_progress", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("abort_rsp_zero", {31'd0, bus.rsp_zero}, 32'd1);
    stale = 0;
    bus.rsp_ready = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) stale++;
    end
    bus.rsp_ready = 1'b0;
    checkOutput("no_stale_response", stale, 32'd0);

    $display("[TB] randomized requests");
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      applyStimulus(op, a, b, refResult(op, a, b), (refResult(op, a, b) == 32'd0),
                    refCycles(op, b), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
